// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: CPU instruction/data SRAM-like ports to a single-outstanding AXI3 master.
// Data requests win over instruction requests; every access is one beat.
module cpu_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state, state_nx;
    logic        src_data, wr_q, aw_done, w_done;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        take_data, take_inst, r_hs, b_hs;
    logic        unused_rid;

    assign take_data    = resetn && state == IDLE && data_req;
    assign take_inst    = resetn && state == IDLE && !data_req && inst_req;
    assign data_addr_ok = take_data;
    assign inst_addr_ok = take_inst;

    assign arvalid = state == RD_ADDR;
    assign rready  = state == RD_DATA;
    assign awvalid = state == WR_REQ && !aw_done;
    assign wvalid  = state == WR_REQ && !w_done;
    assign bready  = state == WR_RESP;
    assign r_hs    = rready && rvalid;
    assign b_hs    = bready && bvalid;

    // Read data is routed by the latched source; rid carries no information here.
    assign unused_rid = ^rid;

    assign arid    = src_data ? ID_DATA : ID_INST;
    assign awid    = arid;
    assign wid     = arid;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign wdata   = wdata_q;
    assign wstrb   = !wr_q ? 4'b0000 :
                     size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                     size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlast   = 1'b1;
    assign arlen   = 4'd0;
    assign awlen   = 4'd0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = 2'd0;
    assign awlock  = 2'd0;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take_data ? (data_wr ? WR_REQ : RD_ADDR) : take_inst ? RD_ADDR : IDLE;
            RD_ADDR: state_nx = arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_nx = rvalid ? IDLE : RD_DATA;
            // Each channel counts as done if it handshook earlier or is handshaking now.
            WR_REQ:  state_nx = (aw_done || awready) && (w_done || wready) ? WR_RESP : WR_REQ;
            WR_RESP: state_nx = bvalid ? IDLE : WR_RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            src_data     <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= 32'h0;
            data_rdata   <= 32'h0;
        end else begin
            state        <= state_nx;
            aw_done      <= state == WR_REQ && (aw_done || awready);
            w_done       <= state == WR_REQ && (w_done || wready);
            inst_data_ok <= r_hs && !src_data;
            data_data_ok <= (r_hs && src_data) || b_hs;
            if (r_hs && src_data)
                data_rdata <= rdata;
            if (r_hs && !src_data)
                inst_rdata <= rdata;
            if (take_data) begin
                src_data <= 1'b1;
                wr_q     <= data_wr;
                size_q   <= data_size == 2'd3 ? 2'd2 : data_size;
                addr_q   <= data_addr;
                wdata_q  <= data_wr ? data_wdata : 32'h0;
            end else if (take_inst) begin
                src_data <= 1'b0;
                wr_q     <= 1'b0;
                size_q   <= 2'd2;
                addr_q   <= inst_addr;
                wdata_q  <= 32'h0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: randomized and directed checks of cpu_axi_bridge against a transaction-level model
// with a bench-driven AXI slave whose ready/valid delays are chosen per transaction.
module tb_cpu_axi_bridge;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        inst_req = 1'b0, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr = 32'h0, inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0, data_addr_ok, data_data_ok;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = 32'h0, data_wdata = 32'h0, data_rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
    logic [31:0] araddr, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'h0;

    int          errors = 0, checks = 0;
    logic [31:0] exp_inst = 32'h0, exp_data = 32'h0;

    always #5 clk = ~clk;

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("rst_axi_payload", araddr | awaddr | wdata | {28'h0, wstrb} | {29'h0, arsize}, 0);
    endtask

    task automatic busy_chk();
        check("busy_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        check("busy_data_ok", {inst_data_ok, data_data_ok}, 0);
    endtask

    // One complete transaction, entered and left at a negedge; d1/d2/d3 are slave stall cycles
    // (read: ar, r; write: aw, w, b).
    task automatic txn(input logic is_data, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                       input int d1, input int d2, input int d3);
        int         bytes, off, dmax;
        logic [3:0] strb;
        logic [2:0] sz;
        bytes = 1 << size;
        off   = int'(addr[1:0]) & (4 - bytes);
        strb  = 4'(((1 << bytes) - 1) << off);
        sz    = is_data ? {1'b0, size} : 3'd2;
        dmax  = d1 > d2 ? d1 : d2;
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_addr = addr;
        end
        #1;
        check("data_addr_ok", data_addr_ok, is_data);
        check("inst_addr_ok", inst_addr_ok, !is_data);
        @(negedge clk);
        if (is_data) data_req = 1'b0; else inst_req = 1'b0;
        if (!wr) begin
            for (int c = 0; c <= d1; c++) begin
                busy_chk();
                check("arvalid", arvalid, 1);
                check("araddr", araddr, addr);
                check("arsize", arsize, sz);
                check("arid", arid, is_data);
                arready = c == d1;
                @(negedge clk);
            end
            arready = 1'b0;
            for (int c = 0; c <= d2; c++) begin
                busy_chk();
                check("rready", rready, 1);
                check("arvalid_drop", arvalid, 0);
                rvalid = c == d2;
                rdata  = c == d2 ? rd : $urandom;
                rid    = 4'($urandom);
                @(negedge clk);
            end
            rvalid = 1'b0;
            if (is_data) exp_data = rd; else exp_inst = rd;
        end else begin
            for (int c = 0; c <= dmax; c++) begin
                busy_chk();
                check("awvalid", awvalid, c <= d1);
                check("wvalid", wvalid, c <= d2);
                if (c <= d1) begin
                    check("awaddr", awaddr, addr);
                    check("awsize", awsize, sz);
                    check("awid", awid, 1);
                end
                if (c <= d2) begin
                    check("wdata", wdata, wd);
                    check("wstrb", wstrb, strb);
                end
                awready = c == d1;
                wready  = c == d2;
                @(negedge clk);
            end
            awready = 1'b0; wready = 1'b0;
            for (int c = 0; c <= d3; c++) begin
                busy_chk();
                check("bready", bready, 1);
                bvalid = c == d3;
                @(negedge clk);
            end
            bvalid = 1'b0;
        end
        check("data_data_ok", data_data_ok, is_data);
        check("inst_data_ok", inst_data_ok, !is_data);
        check("inst_rdata", inst_rdata, exp_inst);
        check("data_rdata", data_rdata, exp_data);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset();
        resetn = 1'b1;
        @(negedge clk);
        chk_reset();
        txn(0, 0, 2, 32'hBFC0_0000, 0, 32'h2408_0001, 0, 3, 0);
        txn(1, 1, 0, 32'h0000_1003, 32'hAB00_0000, 0, 0, 0, 0);
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        txn(1, 0, 2, 32'h0000_2000, 0, 32'h1234_5678, 0, 0, 0);
        txn(0, 0, 2, 32'h0000_0100, 0, 32'h0000_0000, 0, 0, 0);
        txn(1, 1, 2, 32'h0000_4000, 32'hCAFE_F00D, 0, 4, 0, 1);
        txn(1, 1, 1, 32'h0000_2002, 32'h5A5A_0000, 0, 0, 0, 0);
        inst_req = 1'b1; inst_addr = 32'h0000_0200;
        txn(1, 0, 2, 32'h0000_2004, 0, 32'h8765_4321, 1, 10, 0);
        txn(0, 0, 2, 32'h0000_0200, 0, 32'h0BAD_C0DE, 0, 0, 0);
        txn(1, 1, 0, 32'h0000_0001, 32'h0000_EE00, 0, 2, 2, 0);
        for (int i = 0; i < 40; i++) begin
            logic        is_d, w;
            logic [1:0]  sz;
            logic [31:0] a;
            is_d = ($urandom % 3) != 0;
            w    = is_d && $urandom_range(0, 1) == 1;
            sz   = is_d ? 2'($urandom_range(0, 2)) : 2'd2;
            a    = $urandom;
            a    = sz == 2'd2 ? a & ~32'h3 : sz == 2'd1 ? a & ~32'h1 : a;
            txn(is_d, w, sz, a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_3000;
        @(negedge clk);
        data_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rready_before_reset", rready, 1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset();
        resetn = 1'b1; exp_inst = 32'h0; exp_data = 32'h0;
        @(negedge clk);
        check("post_reset_no_ok", {inst_data_ok, data_data_ok}, 0);
        check("post_reset_idle", {arvalid, rready, awvalid, wvalid, bready}, 0);
        txn(0, 0, 2, 32'h0000_0040, 0, 32'h1357_9BDF, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
